// File: rtl/hilo_mac_sequencer.sv
// hilo_mac_sequencer
//   Multi-cycle HI/LO sequencer for the execute stage. Owns the HI/LO
//   register pair and runs MULT, MULTU, MADD and MSUB as a WIDTH-iteration
//   radix-2 shift-add on operand magnitudes, with the sign applied in a final
//   FIX cycle. MTHI/MTLO complete in one cycle. Stall holds MFHI/MFLO until
//   the multiply result is committed.
//
// Ports
//   Clk    in   clock, rising edge
//   Rst    in   synchronous active-high reset
//   Start  in   operation request, sampled only while Busy=0
//   Op     in   0=MULT 1=MULTU 2=MADD 3=MSUB 4=MTHI 5=MTLO 6,7=no-op
//   A      in   rs operand / MTHI-MTLO data
//   B      in   rt operand
//   MfReq  in   MFHI/MFLO present in execute this cycle
//   Busy   out  multiply in progress (registered)
//   Done   out  one-cycle pulse after HI/LO update (registered)
//   Stall  out  pipeline stall request (combinational)
//   Hi     out  HI register
//   Lo     out  LO register
module hilo_mac_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MfReq,
   output logic             Busy,
   output logic             Done,
   output logic             Stall,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MADD  = 3'd2,
      OP_MSUB  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } op_t;

   state_t               state;
   op_t                  op_in;
   op_t                  op_q;
   logic [WIDTH-1:0]     mcand;
   logic [WIDTH-1:0]     mplier;
   logic                 neg;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   acc;

   logic                 is_mul;
   logic                 is_signed;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   addend;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   hilo_next;

   always_comb begin
      op_in     = op_t'(Op);
      is_mul    = ~Op[2];
      is_signed = (op_in != OP_MULTU);
      // Two's-complement negation leaves the most negative value unchanged,
      // which is its correct magnitude when read as unsigned.
      a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
      b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;
      addend    = mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
      prod      = neg ? -acc : acc;
      case (op_q)
         OP_MADD: hilo_next = {Hi, Lo} + prod;
         OP_MSUB: hilo_next = {Hi, Lo} - prod;
         default: hilo_next = prod;
      endcase
      // A read arriving together with a multiply launch is younger and waits.
      Stall = MfReq & (Busy | (Start & ~Busy & is_mul));
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= S_IDLE;
         op_q   <= OP_MULT;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         Hi     <= '0;
         Lo     <= '0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  case (op_in)
                     OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        op_q   <= op_in;
                        acc    <= '0;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= S_RUN;
                     end
                     OP_MTHI: begin
                        Hi   <= A;
                        Done <= 1'b1;
                     end
                     OP_MTLO: begin
                        Lo   <= A;
                        Done <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               acc <= acc + addend;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
            end
            S_FIX: begin
               {Hi, Lo} <= hilo_next;
               Done     <= 1'b1;
               Busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mac_sequencer.sv
module tb_hilo_mac_sequencer;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic [2:0]  Op = 3'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        MfReq = 1'b0;
   logic        Busy, Done, Stall;
   logic [31:0] Hi, Lo;

   always #5 Clk = ~Clk;

   hilo_mac_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .MfReq(MfReq), .Busy(Busy), .Done(Done), .Stall(Stall), .Hi(Hi), .Lo(Lo)
   );

   logic [63:0] exp_q[$];
   logic [63:0] model_hl = '0;
   int          vectors = 0;
   int          miscompares = 0;

   // Reference: plain 64-bit arithmetic on the architectural HI/LO value.
   function automatic logic [63:0] ref_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [63:0] hl);
      logic signed [63:0] sa, sb;
      logic [63:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         3'd0: r = sa * sb;
         3'd1: r = {32'b0, a} * {32'b0, b};
         3'd2: r = hl + sa * sb;
         3'd3: r = hl - sa * sb;
         3'd4: r = {a, hl[31:0]};
         3'd5: r = {hl[63:32], a};
         default: r = hl;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Monitor: every Done pulse must match the oldest outstanding result.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge Clk);
         if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("hilo_result", {Hi, Lo}, e);
            end
         end
      end
   end

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic mf, input logic inj);
      int n;
      int busy_n;
      int stall_bad;
      @(posedge Clk); #1;
      Start = 1'b1; Op = op; A = a; B = b; MfReq = mf;
      if (op <= 3'd5) begin
         model_hl = ref_result(op, a, b, model_hl);
         exp_q.push_back(model_hl);
      end
      @(negedge Clk);
      check("stall_launch", {63'd0, Stall}, {63'd0, (mf && op <= 3'd3)});
      @(posedge Clk); #1;
      Start = 1'b0;
      if (op <= 3'd3) begin
         n = 0; busy_n = 0; stall_bad = 0;
         forever begin
            @(negedge Clk);
            if (Done === 1'b1) break;
            if (n >= 60) begin
               check("done_timeout", 64'd0, 64'd1);
               break;
            end
            if (Busy === 1'b1) busy_n++;
            if (Stall !== mf) stall_bad++;
            if (inj && n == 10) begin
               Start = 1'b1; Op = 3'd0; A = 32'd9; B = 32'd9;
            end
            if (inj && n == 11) Start = 1'b0;
            n++;
         end
         check("latency", 64'(n), 64'd33);
         check("busy_cycles", 64'(busy_n), 64'd33);
         check("stall_run", 64'(stall_bad), 64'd0);
         check("busy_in_done", {63'd0, Busy}, 64'd0);
         check("stall_in_done", {63'd0, Stall}, 64'd0);
      end else begin
         @(negedge Clk);
         check("done_short_op", {63'd0, Done}, {63'd0, (op <= 3'd5)});
         check("busy_short_op", {63'd0, Busy}, 64'd0);
      end
      MfReq = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int d;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      // 1: reset, then idle with MfReq asserted
      Rst = 1'b1; MfReq = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      @(negedge Clk);
      check("rst_hi", {32'd0, Hi}, 64'd0);
      check("rst_lo", {32'd0, Lo}, 64'd0);
      check("rst_busy", {63'd0, Busy}, 64'd0);
      check("rst_done", {63'd0, Done}, 64'd0);
      check("rst_stall", {63'd0, Stall}, 64'd0);
      MfReq = 1'b0;

      // 2: signed multiply
      launch(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      check("mult_neg3x7", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      launch(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      check("mult_minxmin", {Hi, Lo}, 64'h4000_0000_0000_0000);

      // 3: unsigned multiply, single-cycle Done
      launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("multu_max", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
      @(negedge Clk);
      check("done_one_cycle", {63'd0, Done}, 64'd0);

      // 4: MTHI/MTLO then MADD and MSUB
      launch(3'd4, 32'd5, 32'd0, 1'b1, 1'b0);
      launch(3'd5, 32'd6, 32'd0, 1'b1, 1'b0);
      launch(3'd2, 32'd2, 32'd3, 1'b0, 1'b0);
      check("madd", {Hi, Lo}, 64'h0000_0005_0000_000C);
      launch(3'd4, 32'd0, 32'd0, 1'b0, 1'b0);
      launch(3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
      launch(3'd3, 32'h10, 32'd1, 1'b0, 1'b0);
      check("msub", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF5);

      // 5: Start while busy is ignored; stall held throughout
      launch(3'd1, 32'd3, 32'd4, 1'b1, 1'b1);
      check("busy_start_ignored", {Hi, Lo}, 64'h0000_0000_0000_000C);

      // no-op ops
      launch(3'd6, 32'h1111, 32'h2222, 1'b0, 1'b0);
      launch(3'd7, 32'h3333, 32'h4444, 1'b1, 1'b0);

      // randomized mix
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'hFFFF_FFFF;
            2: ra = 32'd0;
            default: ;
         endcase
         launch(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      end

      // 6: reset aborts a MADD mid-run
      launch(3'd4, 32'h1234, 32'd0, 1'b0, 1'b0);
      check("preload_hi", {32'd0, Hi}, 64'h1234);
      @(posedge Clk); #1;
      Start = 1'b1; Op = 3'd2; A = 32'd5; B = 32'd5;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (10) @(posedge Clk);
      #1 Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      model_hl = '0;
      exp_q.delete();
      @(negedge Clk);
      check("abort_busy", {63'd0, Busy}, 64'd0);
      check("abort_hilo", {Hi, Lo}, 64'd0);
      d = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done === 1'b1) d++;
      end
      check("abort_no_done", 64'(d), 64'd0);

      // post-abort operation still works
      launch(3'd0, 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("post_abort_mult", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF9);

      repeat (3) @(negedge Clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
